// File: rtl/periph_bridge_pkg.sv
// Shared types and constants for the peripheral bridge.
//   mem_store_type_t : store width requested by the core (none = load)
//   periph_state_t   : bridge FSM states
//   PERIPH_ERR_DATA  : load data returned on an unmapped access or timeout
//   idx_width()      : width of a slave index for a given slave count
package periph_bridge_pkg;

    typedef enum logic [2:0] {
        StoreNone,
        StoreByte,
        StoreHalf,
        StoreWord,
        StoreDouble
    } mem_store_type_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } periph_state_t;

    localparam logic [63:0] PERIPH_ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_decode.sv
// Combinational request decode for the peripheral bridge.
//   i_addr       : byte address from the core
//   i_store_type : store width (none = load)
//   o_mapped     : address lies inside one of the slave windows
//   o_idx        : slave index
//   o_offset     : byte offset within the slave window
//   o_wstrb      : byte-lane strobes (0 for loads)
//   o_write      : request is a store
module periph_decode
    import periph_bridge_pkg::*;
#(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int unsigned NUM_SLAVES      = 4,
    parameter int unsigned SLAVE_SPAN_LOG2 = 12,
    parameter int unsigned IDX_W           = 2
) (
    input  logic [63:0]                i_addr,
    input  mem_store_type_t            i_store_type,
    output logic                       o_mapped,
    output logic [IDX_W-1:0]           o_idx,
    output logic [SLAVE_SPAN_LOG2-1:0] o_offset,
    output logic [7:0]                 o_wstrb,
    output logic                       o_write
);

    // End of the window computed in 65 bits so a window near the top of the
    // address space cannot wrap and alias low addresses.
    localparam logic [64:0] WinEnd = {1'b0, PERIPHERAL_BASE} +
                                     (65'(NUM_SLAVES) << SLAVE_SPAN_LOG2);

    logic [63:0] w_rel;

    assign w_rel    = i_addr - PERIPHERAL_BASE;
    assign o_mapped = (i_addr >= PERIPHERAL_BASE) && ({1'b0, i_addr} < WinEnd);
    assign o_idx    = IDX_W'(w_rel >> SLAVE_SPAN_LOG2);
    assign o_offset = w_rel[SLAVE_SPAN_LOG2-1:0];
    assign o_write  = (i_store_type != StoreNone);

    // Low address bits below the access size are dropped, not faulted.
    always_comb begin
        o_wstrb = 8'h00;
        case (i_store_type)
            StoreByte:   o_wstrb = 8'b1 << i_addr[2:0];
            StoreHalf:   o_wstrb = 8'b11 << {i_addr[2:1], 1'b0};
            StoreWord:   o_wstrb = 8'hF << {i_addr[2], 2'b0};
            StoreDouble: o_wstrb = 8'hFF;
            default:     o_wstrb = 8'h00;
        endcase
    end

endmodule

// File: rtl/periph_bridge.sv
// Bridges the core's single-outstanding peripheral port to NUM_SLAVES
// APB-style slaves (setup/access phases) with a per-access timeout.
//   clock, reset             : clock, async active-low reset
//   d_addr/d_wdata/...       : core request (held until d_ready)
//   d_rdata, d_ready         : one-cycle completion pulse and load data
//   p_sel/p_enable/p_write   : slave select, access phase, write flag
//   p_addr/p_wdata/p_wstrb   : window offset, store data, byte lanes
//   p_rdata, p_ready         : per-slave read data (64 bits each) and done
//   bus_error, err_addr      : error pulse and sticky faulting address
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int unsigned NUM_SLAVES      = 4,
    parameter int unsigned SLAVE_SPAN_LOG2 = 12,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [63:0]                d_addr,
    input  logic [63:0]                d_wdata,
    input  mem_store_type_t            d_store_type,
    input  logic                       d_valid,
    output logic [63:0]                d_rdata,
    output logic                       d_ready,
    output logic [NUM_SLAVES-1:0]      p_sel,
    output logic                       p_enable,
    output logic                       p_write,
    output logic [SLAVE_SPAN_LOG2-1:0] p_addr,
    output logic [63:0]                p_wdata,
    output logic [7:0]                 p_wstrb,
    input  logic [NUM_SLAVES*64-1:0]   p_rdata,
    input  logic [NUM_SLAVES-1:0]      p_ready,
    output logic                       bus_error,
    output logic [63:0]                err_addr
);

    localparam int unsigned IdxW = idx_width(NUM_SLAVES);

    periph_state_t              r_state, w_state_next;
    logic [63:0]                r_addr, r_wdata, r_rdata, r_err_addr;
    logic [7:0]                 r_wstrb;
    logic                       r_write, r_err;
    logic [IdxW-1:0]            r_idx;
    logic [SLAVE_SPAN_LOG2-1:0] r_offset;
    logic [15:0]                r_cnt;

    logic                       w_mapped, w_write, w_slave_ready, w_timeout, w_active;
    logic [IdxW-1:0]            w_idx;
    logic [SLAVE_SPAN_LOG2-1:0] w_offset;
    logic [7:0]                 w_wstrb;
    logic [63:0]                w_slave_rdata;
    logic [16:0]                w_cnt_inc;

    periph_decode #(
        .PERIPHERAL_BASE (PERIPHERAL_BASE),
        .NUM_SLAVES      (NUM_SLAVES),
        .SLAVE_SPAN_LOG2 (SLAVE_SPAN_LOG2),
        .IDX_W           (IdxW)
    ) u_decode (
        .i_addr       (d_addr),
        .i_store_type (d_store_type),
        .o_mapped     (w_mapped),
        .o_idx        (w_idx),
        .o_offset     (w_offset),
        .o_wstrb      (w_wstrb),
        .o_write      (w_write)
    );

    assign w_slave_ready = p_ready[r_idx];
    assign w_slave_rdata = p_rdata[{r_idx, 6'd0} +: 64];
    assign w_cnt_inc     = {1'b0, r_cnt} + 17'd1;
    assign w_timeout     = (w_cnt_inc == 17'(TIMEOUT));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (d_valid) w_state_next = w_mapped ? StSetup : StResp;
            StSetup:  w_state_next = StAccess;
            // Slave completion takes priority over a coincident timeout.
            StAccess: if (w_slave_ready || w_timeout) w_state_next = StResp;
            StResp:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err_addr <= '0;
            r_wstrb    <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
            r_offset   <= '0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (d_valid) begin
                        r_addr   <= d_addr;
                        r_wdata  <= d_wdata;
                        r_wstrb  <= w_wstrb;
                        r_write  <= w_write;
                        r_idx    <= w_idx;
                        r_offset <= w_offset;
                        r_rdata  <= '0;
                        r_err    <= !w_mapped;
                        if (!w_mapped) r_err_addr <= d_addr;
                    end
                end
                StSetup: r_cnt <= '0;
                StAccess: begin
                    r_cnt <= w_cnt_inc[15:0];
                    if (w_slave_ready) begin
                        if (!r_write) r_rdata <= w_slave_rdata;
                    end else if (w_timeout) begin
                        r_err      <= 1'b1;
                        r_err_addr <= r_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decode straight from state so reset drops them immediately.
    assign w_active  = (r_state == StSetup) || (r_state == StAccess);
    assign p_sel     = w_active ? (NUM_SLAVES'(1) << r_idx) : '0;
    assign p_enable  = (r_state == StAccess);
    assign p_write   = w_active && r_write;
    assign p_addr    = w_active ? r_offset : '0;
    assign p_wdata   = w_active ? r_wdata : '0;
    assign p_wstrb   = w_active ? r_wstrb : '0;

    assign d_ready   = (r_state == StResp);
    assign bus_error = d_ready && r_err;
    assign d_rdata   = !d_ready ? '0 : (r_err ? PERIPH_ERR_DATA : r_rdata);
    assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_periph_bridge.sv
module tb_periph_bridge;
    import periph_bridge_pkg::*;

    localparam logic [63:0] S0 = 64'hA0A0_A0A0_0000_0000;
    localparam logic [63:0] S1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] S2 = 64'h2222_3333_4444_5555;
    localparam logic [63:0] S3 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic            clk;
    logic            rst_n;
    logic [63:0]     d_addr, d_wdata, d_rdata, p_wdata, err_addr;
    mem_store_type_t d_store_type;
    logic            d_valid, d_ready, p_enable, p_write, bus_error;
    logic [3:0]      p_sel, p_ready;
    logic [11:0]     p_addr;
    logic [7:0]      p_wstrb;
    logic [255:0]    p_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] last_err = '0;

    periph_bridge #(
        .PERIPHERAL_BASE (64'h2000_0000),
        .NUM_SLAVES      (4),
        .SLAVE_SPAN_LOG2 (12),
        .TIMEOUT         (4)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_store_type (d_store_type),
        .d_valid      (d_valid),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .p_sel        (p_sel),
        .p_enable     (p_enable),
        .p_write      (p_write),
        .p_addr       (p_addr),
        .p_wdata      (p_wdata),
        .p_wstrb      (p_wstrb),
        .p_rdata      (p_rdata),
        .p_ready      (p_ready),
        .bus_error    (bus_error),
        .err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [63:0]     addr;
        logic [63:0]     wdata;
        mem_store_type_t st;
        logic [3:0]      ready;
        logic [3:0]      sel;
        logic [11:0]     paddr;
        logic            pwrite;
        logic [7:0]      strb;
        logic [63:0]     rdata;
        logic            err;
        int              lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat;
        logic        got;
        logic [3:0]  csel;
        logic [11:0] caddr;
        logic        cw;
        logic [7:0]  cs;
        logic [63:0] cwd, rd, ea;
        logic        be;
        lat = 0; got = 1'b0; csel = '0; caddr = '0; cw = 1'b0; cs = '0;
        cwd = '0; rd = '0; ea = '0; be = 1'b0;
        d_addr = v.addr; d_wdata = v.wdata; d_store_type = v.st;
        p_ready = v.ready; d_valid = 1'b1;
        while (!got && lat < 20) begin
            step();
            lat++;
            if (p_sel != 4'b0 && csel == 4'b0) begin
                csel = p_sel; caddr = p_addr; cw = p_write; cs = p_wstrb; cwd = p_wdata;
            end
            if (d_ready) begin
                got = 1'b1; rd = d_rdata; be = bus_error; ea = err_addr;
            end
        end
        d_valid = 1'b0;
        p_ready = 4'b0;
        if (v.err) last_err = v.addr;
        chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
        chk({v.name, " p_sel"}, 64'(csel), 64'(v.sel));
        chk({v.name, " p_addr"}, 64'(caddr), 64'(v.paddr));
        chk({v.name, " p_write"}, 64'(cw), 64'(v.pwrite));
        chk({v.name, " p_wstrb"}, 64'(cs), 64'(v.strb));
        if (v.pwrite) chk({v.name, " p_wdata"}, cwd, v.wdata);
        chk({v.name, " d_rdata"}, rd, v.rdata);
        chk({v.name, " bus_error"}, 64'(be), 64'(v.err));
        chk({v.name, " err_addr"}, ea, last_err);
        step();
        chk({v.name, " d_ready after resp"}, 64'(d_ready), 64'd0);
    endtask

    initial begin
        int          pulses;
        int          p2_cyc;
        logic [3:0]  seen;
        logic [63:0] r1, r2;

        vecs[0]  = '{"ld_dbl_s1",   64'h2000_1008, 64'h0, StoreNone, 4'hF,
                     4'b0010, 12'h008, 1'b0, 8'h00, S1, 1'b0, 3};
        vecs[1]  = '{"st_byte_s0",  64'h2000_0005, 64'h0000_AB00_0000_0000, StoreByte, 4'hF,
                     4'b0001, 12'h005, 1'b1, 8'h20, 64'h0, 1'b0, 3};
        vecs[2]  = '{"unmap_low",   64'h1FFF_FFF8, 64'h0, StoreNone, 4'hF,
                     4'b0000, 12'h000, 1'b0, 8'h00, ERR, 1'b1, 1};
        vecs[3]  = '{"unmap_high",  64'h2000_4000, 64'h0, StoreNone, 4'hF,
                     4'b0000, 12'h000, 1'b0, 8'h00, ERR, 1'b1, 1};
        vecs[4]  = '{"st_half_s3",  64'h2000_3006, 64'h1234_0000_0000_0000, StoreHalf, 4'hF,
                     4'b1000, 12'h006, 1'b1, 8'hC0, 64'h0, 1'b0, 3};
        vecs[5]  = '{"st_word_s2",  64'h2000_2004, 64'hCAFE_F00D_0000_0000, StoreWord, 4'hF,
                     4'b0100, 12'h004, 1'b1, 8'hF0, 64'h0, 1'b0, 3};
        vecs[6]  = '{"st_dbl_s0",   64'h2000_0010, 64'h1122_3344_5566_7788, StoreDouble, 4'hF,
                     4'b0001, 12'h010, 1'b1, 8'hFF, 64'h0, 1'b0, 3};
        vecs[7]  = '{"st_word_mis", 64'h2000_0003, 64'h0000_0000_A5A5_A5A5, StoreWord, 4'hF,
                     4'b0001, 12'h003, 1'b1, 8'h0F, 64'h0, 1'b0, 3};
        vecs[8]  = '{"st_half_mis", 64'h2000_1FFF, 64'hBEEF_0000_0000_0000, StoreHalf, 4'hF,
                     4'b0010, 12'hFFF, 1'b1, 8'hC0, 64'h0, 1'b0, 3};
        vecs[9]  = '{"ld_s3_top",   64'h2000_3FF8, 64'h0, StoreNone, 4'hF,
                     4'b1000, 12'hFF8, 1'b0, 8'h00, S3, 1'b0, 3};
        vecs[10] = '{"unmap_alias", 64'h1_2000_1000, 64'h0, StoreNone, 4'hF,
                     4'b0000, 12'h000, 1'b0, 8'h00, ERR, 1'b1, 1};
        vecs[11] = '{"tmo_wrong_rdy", 64'h2000_1000, 64'h0, StoreNone, 4'b1101,
                     4'b0010, 12'h000, 1'b0, 8'h00, ERR, 1'b1, 6};
        vecs[12] = '{"tmo_store",   64'h2000_2007, 64'h7700_0000_0000_0000, StoreByte, 4'h0,
                     4'b0100, 12'h007, 1'b1, 8'h80, ERR, 1'b1, 6};

        rst_n = 1'b0; d_addr = '0; d_wdata = '0; d_store_type = StoreNone;
        d_valid = 1'b0; p_ready = '0; p_rdata = {S3, S2, S1, S0};
        #12;
        chk("rst d_ready", 64'(d_ready), 64'd0);
        chk("rst bus_error", 64'(bus_error), 64'd0);
        chk("rst p_sel", 64'(p_sel), 64'd0);
        chk("rst p_enable/p_write", 64'({p_enable, p_write}), 64'd0);
        chk("rst p_wstrb", 64'(p_wstrb), 64'd0);
        chk("rst p_addr", 64'(p_addr), 64'd0);
        chk("rst p_wdata", p_wdata, 64'd0);
        chk("rst d_rdata", d_rdata, 64'd0);
        chk("rst err_addr", err_addr, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // p_ready lands on the cycle the counter reaches TIMEOUT: success wins.
        d_addr = 64'h2000_1008; d_store_type = StoreNone; p_ready = 4'b0; d_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("race still in access", 64'({p_enable, d_ready}), 64'b10);
        p_ready = 4'b0010;
        step();
        chk("race d_ready", 64'(d_ready), 64'd1);
        chk("race bus_error", 64'(bus_error), 64'd0);
        chk("race d_rdata", d_rdata, S1);
        d_valid = 1'b0; p_ready = 4'b0;
        step();

        // Back-to-back with d_valid held; core switches address on d_ready.
        d_addr = 64'h2000_2000; d_store_type = StoreNone; p_ready = 4'hF; d_valid = 1'b1;
        pulses = 0; p2_cyc = 0; seen = '0; r1 = '0; r2 = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen = seen | p_sel;
            if (d_ready) begin
                pulses++;
                if (pulses == 1) begin
                    r1 = d_rdata;
                    d_addr = 64'h2000_3000;
                end else begin
                    r2 = d_rdata;
                    p2_cyc = i + 1;
                    d_valid = 1'b0;
                end
            end
        end
        p_ready = 4'b0;
        chk("b2b pulses", 64'(pulses), 64'd2);
        chk("b2b slaves seen", 64'(seen), 64'b1100);
        chk("b2b first rdata", r1, S2);
        chk("b2b second rdata", r2, S3);
        chk("b2b second pulse cycle", 64'(p2_cyc), 64'd7);

        // d_valid dropped in SETUP: request fields already latched.
        d_addr = 64'h2000_1008; p_ready = 4'hF; d_valid = 1'b1;
        step();
        d_valid = 1'b0; d_addr = 64'h0;
        pulses = 0; r1 = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (d_ready) begin
                pulses++;
                r1 = d_rdata;
            end
        end
        p_ready = 4'b0;
        chk("flush pulses", 64'(pulses), 64'd1);
        chk("flush rdata", r1, S1);

        // Reset pulsed during ACCESS.
        d_addr = 64'h2000_2010; p_ready = 4'b0; d_valid = 1'b1;
        step();
        step();
        chk("pre-reset p_sel", 64'(p_sel), 64'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset p_sel", 64'(p_sel), 64'd0);
        chk("async reset p_enable", 64'(p_enable), 64'd0);
        d_valid = 1'b0;
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (d_ready) pulses++;
        end
        chk("reset no d_ready", 64'(pulses), 64'd0);
        chk("reset err_addr cleared", err_addr, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
